// File: rtl/network_interface_controller.sv
// NIC endpoint for one mesh node: CPU-mapped registers, one single-entry buffer per direction.
// Bit 0 is the MSB on every data bus; status flags live in the last bit (DATA_WIDTH-1).
module network_interface_controller #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [0:1]            addr,
   input  logic [0:DATA_WIDTH-1] d_in,
   output logic [0:DATA_WIDTH-1] d_out,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [0:DATA_WIDTH-1] net_di,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [0:DATA_WIDTH-1] net_do,
   input  logic                  net_polarity
);

   localparam logic [0:1] ADDR_IN_BUF     = 2'b00;
   localparam logic [0:1] ADDR_IN_STATUS  = 2'b01;
   localparam logic [0:1] ADDR_OUT_BUF    = 2'b10;
   localparam logic [0:1] ADDR_OUT_STATUS = 2'b11;

   logic                  in_full;
   logic                  out_full;
   logic [0:DATA_WIDTH-1] in_buf;
   logic [0:DATA_WIDTH-1] out_buf;

   logic cpu_rd;
   logic cpu_wr;
   logic eject;
   logic read_clear;
   logic write_ok;
   logic inject;

   assign cpu_rd     = nicEn & ~nicWrEn;
   assign cpu_wr     = nicEn & nicWrEn;
   assign eject      = net_si & ~in_full;
   assign read_clear = cpu_rd & in_full & (addr == ADDR_IN_BUF);
   // A write on an injection edge sees out_full=1 and is dropped.
   assign write_ok   = cpu_wr & ~out_full & (addr == ADDR_OUT_BUF);
   assign inject     = out_full & net_ro & (out_buf[0] == net_polarity);

   assign net_ri = ~in_full;

   // Router-to-CPU channel; eject and read_clear can never coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_full <= 1'b0;
         in_buf  <= '0;
      end else if (eject) begin
         in_full <= 1'b1;
         in_buf  <= net_di;
      end else if (read_clear) begin
         in_full <= 1'b0;
      end
   end

   // CPU-to-router channel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_full <= 1'b0;
         out_buf  <= '0;
         net_so   <= 1'b0;
         net_do   <= '0;
      end else begin
         net_so <= inject;
         if (inject) begin
            net_do   <= out_buf;
            out_full <= 1'b0;
         end else if (write_ok) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
         end
      end
   end

   always_comb begin
      d_out = '0;
      if (cpu_rd) begin
         case (addr)
            ADDR_IN_BUF:     d_out = in_buf;
            ADDR_IN_STATUS:  d_out[DATA_WIDTH-1] = in_full;
            ADDR_OUT_BUF:    d_out = out_buf;
            ADDR_OUT_STATUS: d_out[DATA_WIDTH-1] = out_full;
            default:         d_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_network_interface_controller.sv
// Bench for network_interface_controller: fixed vector table, directed corner cases,
// and randomized traffic checked against a queue-based model of the two channels.
module tb_network_interface_controller;

   localparam int DW = 64;
   typedef logic [0:DW-1] word_t;

   typedef struct {
      logic       en;
      logic       we;
      logic [0:1] a;
      word_t      din;
      logic       si;
      word_t      di;
      logic       ro;
      logic       pol;
      word_t      exp_dout;
      logic       exp_ri;
      logic       exp_so;
      word_t      exp_do;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [0:1] addr;
   word_t      d_in, d_out, net_di, net_do;
   logic       nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

   int tests = 0;
   int fails = 0;

   // Model: each channel is a queue holding at most one packet.
   word_t m_in[$];
   word_t m_out[$];
   word_t m_in_last, m_out_last, m_do;
   logic  m_so;

   vec_t tbl[18];

   network_interface_controller #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
      .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
      .net_polarity(net_polarity)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input word_t act, input word_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic en, we, input logic [0:1] a, input word_t din,
                               input logic si, input word_t di, input logic ro, pol,
                               input word_t edout, input logic eri, eso, input word_t edo);
      vec_t v;
      v.en = en; v.we = we; v.a = a; v.din = din; v.si = si; v.di = di;
      v.ro = ro; v.pol = pol; v.exp_dout = edout; v.exp_ri = eri;
      v.exp_so = eso; v.exp_do = edo;
      return v;
   endfunction

   function automatic word_t model_dout(input logic en, we, input logic [0:1] a);
      word_t r = '0;
      if (en && !we) begin
         case (a)
            2'd0: r = m_in_last;
            2'd1: r[DW-1] = (m_in.size() != 0);
            2'd2: r = m_out_last;
            default: r[DW-1] = (m_out.size() != 0);
         endcase
      end
      return r;
   endfunction

   task automatic model_reset();
      m_in.delete(); m_out.delete();
      m_in_last = '0; m_out_last = '0; m_do = '0; m_so = 1'b0;
   endtask

   task automatic model_edge(input vec_t v);
      bit can_eject, do_clear, do_write, do_inject;
      can_eject = (m_in.size() == 0) && v.si;
      do_clear  = (m_in.size() != 0) && v.en && !v.we && (v.a == 2'd0);
      do_write  = (m_out.size() == 0) && v.en && v.we && (v.a == 2'd2);
      do_inject = (m_out.size() != 0) && v.ro && (m_out[0][0] == v.pol);
      if (can_eject) begin
         m_in.push_back(v.di);
         m_in_last = v.di;
      end
      if (do_clear) void'(m_in.pop_front());
      m_so = do_inject;
      if (do_inject) m_do = m_out.pop_front();
      if (do_write) begin
         m_out.push_back(v.din);
         m_out_last = v.din;
      end
   endtask

   // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
   task automatic apply(input vec_t v, input bit use_tbl, input string tag);
      word_t e_dout, e_do;
      logic  e_ri, e_so;
      nicEn = v.en; nicWrEn = v.we; addr = v.a; d_in = v.din;
      net_si = v.si; net_di = v.di; net_ro = v.ro; net_polarity = v.pol;
      #1;
      e_dout = use_tbl ? v.exp_dout : model_dout(v.en, v.we, v.a);
      e_ri   = use_tbl ? v.exp_ri   : (m_in.size() == 0);
      check({tag, " d_out"}, d_out, e_dout);
      check({tag, " net_ri"}, word_t'(net_ri), word_t'(e_ri));
      model_edge(v);
      @(posedge clk);
      #1;
      e_so = use_tbl ? v.exp_so : m_so;
      e_do = use_tbl ? v.exp_do : m_do;
      check({tag, " net_so"}, word_t'(net_so), word_t'(e_so));
      check({tag, " net_do"}, net_do, e_do);
   endtask

   function automatic vec_t idle(input logic ro, pol);
      return mk(0, 0, 2'd0, '0, 0, '0, ro, pol, '0, 0, 0, '0);
   endfunction

   function automatic vec_t rd(input logic [0:1] a, input logic si, input word_t di);
      return mk(1, 0, a, '0, si, di, 0, 0, '0, 0, 0, '0);
   endfunction

   function automatic vec_t wr(input word_t din, input logic ro, pol);
      return mk(1, 1, 2'd2, din, 0, '0, ro, pol, '0, 0, 0, '0);
   endfunction

   initial begin
      word_t c0123 = 64'h0123_4567_89AB_CDEF;
      word_t cdead = 64'hDEAD_BEEF_0000_0042;
      word_t one   = 64'd1;
      int    pulses;
      vec_t  v;

      // Output path, write-while-full, input path, stale reads, ignored writes.
      tbl[0]  = mk(1, 1, 2'd2, c0123, 0, '0, 0, 0, '0,    1, 0, '0);
      tbl[1]  = mk(1, 0, 2'd3, '0,    0, '0, 0, 0, one,   1, 0, '0);
      tbl[2]  = mk(1, 0, 2'd2, '0,    0, '0, 0, 0, c0123, 1, 0, '0);
      tbl[3]  = mk(0, 0, 2'd0, '0,    0, '0, 1, 0, '0,    1, 1, c0123);
      tbl[4]  = mk(1, 0, 2'd3, '0,    0, '0, 1, 0, '0,    1, 0, c0123);
      tbl[5]  = mk(1, 1, 2'd2, 64'h11, 0, '0, 0, 0, '0,   1, 0, c0123);
      tbl[6]  = mk(1, 1, 2'd2, 64'h22, 0, '0, 0, 0, '0,   1, 0, c0123);
      tbl[7]  = mk(1, 0, 2'd2, '0,    0, '0, 0, 0, 64'h11, 1, 0, c0123);
      tbl[8]  = mk(0, 0, 2'd0, '0,    0, '0, 1, 0, '0,    1, 1, 64'h11);
      tbl[9]  = mk(0, 0, 2'd0, '0,    0, '0, 1, 0, '0,    1, 0, 64'h11);
      tbl[10] = mk(0, 0, 2'd0, '0,    1, cdead, 0, 0, '0, 1, 0, 64'h11);
      tbl[11] = mk(1, 0, 2'd1, '0,    1, 64'h7, 0, 0, one, 0, 0, 64'h11);
      tbl[12] = mk(1, 0, 2'd0, '0,    1, 64'h7, 0, 0, cdead, 0, 0, 64'h11);
      tbl[13] = mk(1, 0, 2'd1, '0,    1, 64'h7, 0, 0, '0,  1, 0, 64'h11);
      tbl[14] = mk(1, 0, 2'd0, '0,    0, '0, 0, 0, 64'h7, 0, 0, 64'h11);
      tbl[15] = mk(1, 0, 2'd0, '0,    0, '0, 0, 0, 64'h7, 1, 0, 64'h11);
      tbl[16] = mk(1, 1, 2'd0, 64'hFF, 0, '0, 0, 0, '0,   1, 0, 64'h11);
      tbl[17] = mk(1, 0, 2'd1, '0,    0, '0, 0, 0, '0,    1, 0, 64'h11);

      reset = 1'b1; nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd0; d_in = '0;
      net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
      model_reset();
      #12;
      check("reset d_out", d_out, '0);
      check("reset net_ri", word_t'(net_ri), one);
      check("reset net_so", word_t'(net_so), '0);
      check("reset net_do", net_do, '0);
      reset = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[i]) apply(tbl[i], 1'b1, $sformatf("tbl[%0d]", i));

      // Polarity mismatch holds the packet until the router flips polarity.
      apply(wr(64'h8000_0000_0000_0001, 1, 0), 1'b0, "pol write");
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         apply(idle(1, 0), 1'b0, "pol hold");
         if (net_so) pulses++;
      end
      check("pol no pulse while mismatched", word_t'(pulses), '0);
      apply(idle(1, 1), 1'b0, "pol match");
      check("pol pulse", word_t'(net_so), one);
      check("pol data", net_do, 64'h8000_0000_0000_0001);
      apply(idle(1, 1), 1'b0, "pol single pulse");
      check("pol pulse one cycle", word_t'(net_so), '0);

      // Back-pressure: second packet waits until the first is read out.
      apply(mk(0, 0, 2'd0, '0, 1, 64'hA1, 0, 0, '0, 0, 0, '0), 1'b0, "bp first");
      for (int i = 0; i < 3; i++)
         apply(mk(0, 0, 2'd0, '0, 1, 64'hB2, 0, 0, '0, 0, 0, '0), 1'b0, "bp hold");
      check("bp net_ri low", word_t'(net_ri), '0);
      nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd0; #1;
      check("bp keeps first", d_out, 64'hA1);
      apply(rd(2'd0, 1, 64'hB2), 1'b0, "bp clear");
      apply(rd(2'd1, 1, 64'hB2), 1'b0, "bp second status");
      apply(rd(2'd0, 0, '0), 1'b0, "bp second read");

      // Reset asynchronously between edges with both channels full.
      apply(wr(64'hAA, 0, 0), 1'b0, "rst fill out");
      apply(mk(0, 0, 2'd0, '0, 1, 64'h55, 0, 0, '0, 0, 0, '0), 1'b0, "rst fill in");
      nicEn = 1'b0; net_si = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("midrst net_ri", word_t'(net_ri), one);
      check("midrst net_so", word_t'(net_so), '0);
      nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd3; #1;
      check("midrst out status", d_out, '0);
      addr = 2'd1; #1;
      check("midrst in status", d_out, '0);
      reset = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         v = mk($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                {$urandom(), $urandom()}, $urandom_range(0, 1), {$urandom(), $urandom()},
                ($urandom_range(0, 3) != 0), $urandom_range(0, 1), '0, 0, 0, '0);
         if ($urandom_range(0, 2) == 0) begin
            v.en = 1'b1; v.we = 1'b1; v.a = 2'd2;
         end
         apply(v, 1'b0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/network_interface_controller.md
Name: network_interface_controller

Overview:
CPU-side responder for the processor's NIC port (nicEn/nicWrEn/addr_nic/d_in_nic/d_out_nic) and router-side injection/ejection endpoint for one mesh node. It holds one single-entry output-channel buffer (CPU→router) and one single-entry input-channel buffer (router→CPU). It exposes four CPU-addressable registers. CPU reads are combinational so the CPU can capture d_out in its WB stage in the same cycle it asserts nicEn.

Parameters:
DATA_WIDTH, 64, packet and CPU data width; bit 0 is the MSB.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
addr  in  2  [0:1] register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
d_in  in  DATA_WIDTH  [0:63] CPU write data
d_out  out  DATA_WIDTH  [0:63] CPU read data, combinational
nicEn  in  1  access enable
nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn
net_si  in  1  router has a packet on net_di for this node
net_ri  out  1  NIC can accept a packet
net_di  in  DATA_WIDTH  ejected packet from router
net_so  out  1  packet valid on net_do; one-cycle pulse
net_ro  in  1  router input port ready
net_do  out  DATA_WIDTH  injected packet
net_polarity  in  1  router's current virtual-channel polarity

Behaviour:
- Reset (async, immediate): in_full=0, out_full=0, in_buf=0, out_buf=0, net_so=0, net_do=0. Derived outputs follow: net_ri=1, d_out=0.
- d_out, combinational on addr when nicEn=1 and nicWrEn=0:
  - 00 → in_buf
  - 01 → {63'b0, in_full}, status in bit 63
  - 10 → out_buf
  - 11 → {63'b0, out_full}
  - d_out=0 when nicEn=0 or nicWrEn=1.
- net_ri = ~in_full, combinational.
- Ejection: at an edge with net_si=1 and in_full=0: in_buf<=net_di, in_full<=1. When in_full=1, net_si is ignored; the router must hold the packet.
- CPU read-clear: at an edge with nicEn=1, nicWrEn=0, addr=00, in_full=1: in_full<=0. in_buf keeps its value.
  - Reading addr 00 while empty returns stale in_buf and changes no state.
  - Ejection and read-clear are mutually exclusive on one edge: one requires in_full=0, the other in_full=1. After a clear, the next edge may accept a new packet.
- CPU write: at an edge with nicEn=1, nicWrEn=1, addr=10, out_full=0: out_buf<=d_in, out_full<=1.
  - A write when out_full=1 is dropped; out_buf is unchanged.
  - Writes to addr 00, 01 or 11 are ignored.
- Injection (registered), on an edge:
  - If out_full=1, net_ro=1 and out_buf[0]==net_polarity: net_so<=1, net_do<=out_buf, out_full<=0.
  - Otherwise net_so<=0; net_do holds its last value.
  - Fullness is sampled before the edge, so a CPU write on an injection edge is dropped. The CPU must poll addr 11 first.
- Minimum per-packet period: 2 cycles for each channel. The earliest write after an injection is the following edge.
- Status bits reflect registered state only; there is no bypass.

Test Plan:
1. Reset mid-operation: with out_full=1 and in_full=1, assert reset asynchronously between edges → net_ri=1 immediately; net_so=0; read addr 11 and addr 01 both return 0.
2. Output path, polarity match: write 64'h0123_4567_89AB_CDEF to addr 10 with net_ro=0, net_polarity=0 (out_buf[0]=0) → addr 11 reads 1; raise net_ro → next edge net_so=1 for exactly one cycle, net_do=0x0123456789ABCDEF, addr 11 reads 0.
3. Polarity mismatch: write 64'h8000_0000_0000_0001 with net_ro=1, net_polarity=0 → no net_so for 5 cycles; toggle net_polarity=1 → net_so pulse with net_do=0x8000000000000001.
4. Write while full: after writing 0x11, write 0x22 before injection → injected net_do=0x11; 0x22 is never sent.
5. Input path: net_si=1, net_di=0xDEAD_BEEF_0000_0042 → net_ri drops next cycle; addr 01 reads 1; read addr 00 returns 0xDEADBEEF00000042 and clears; the next edge accepts a held second packet 0x7.
6. Back-pressure: hold net_si=1 with two distinct packets while the CPU does not read → the second packet is not latched and in_buf stays the first; after a read-clear, the second is accepted on the following edge.
